// File: rtl/miner_pkg.sv
// Shared miner constants: default nonce width and the widths of the share
// queue's statistics counters.
package miner_pkg;
   localparam int NONCE_W_DEF = 32;
   localparam int DROP_W      = 16;
   localparam int HASH_CNT_W  = 48;
endpackage

// File: rtl/share_ring.sv
// Share storage: DEPTH x NONCE_W registers, one write port, one registered read port.
// The read register forwards a same-cycle write so a fresh head is visible next cycle.
module share_ring #(
   parameter int DEPTH   = 8,
   parameter int NONCE_W = 32,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [NONCE_W-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [NONCE_W-1:0] rdata
);
   logic [NONCE_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
   end
endmodule

// File: rtl/share_queue.sv
// Queue of winning nonces between hash comparator and share consumer; drops
// (counted, sticky flag) when full. SHARE_QUEUE_STATS_EN adds a 48-bit hash counter.
module share_queue import miner_pkg::*; #(
   parameter int DEPTH   = 8,
   parameter int NONCE_W = NONCE_W_DEF,
   localparam int AW     = $clog2(DEPTH),
   localparam int LW     = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  res_valid,
   input  logic                  res_hit,
   input  logic [NONCE_W-1:0]    res_nonce,
   input  logic                  flush,
   output logic                  share_valid,
   input  logic                  share_ready,
   output logic [NONCE_W-1:0]    share_nonce,
   output logic [LW-1:0]         level,
   output logic [DROP_W-1:0]     dropped,
   output logic                  overflow
`ifdef SHARE_QUEUE_STATS_EN
   ,
   output logic [HASH_CNT_W-1:0] hash_count
`endif
);
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
   logic [LW-1:0] count;
   logic          hit, pop, full, push, drop;

   assign hit         = res_valid & res_hit;
   assign full        = (count == FULL);
   assign share_valid = (count != '0);
   assign pop         = share_valid & share_ready;
   // A full queue still accepts a hit when the head leaves in the same cycle.
   assign push        = hit & ~flush & (~full | pop);
   assign drop        = hit & ~flush & full & ~pop;
   assign rd_ptr_nxt  = (pop & ~flush) ? rd_ptr + 1'b1 : rd_ptr;
   assign level       = count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         dropped  <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         wr_ptr <= rd_ptr;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_ptr_nxt;
         count  <= count + LW'(push) - LW'(pop);
         if (drop) begin
            overflow <= 1'b1;
            if (dropped != '1) dropped <= dropped + 1'b1;
         end
      end
   end

`ifdef SHARE_QUEUE_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            hash_count <= '0;
      else if (res_valid) hash_count <= hash_count + 1'b1;
   end
`endif

   // Read address is the post-edge head so share_nonce tracks rd_ptr.
   share_ring #(.DEPTH(DEPTH), .NONCE_W(NONCE_W)) u_ring (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (res_nonce),
      .raddr (rd_ptr_nxt),
      .rdata (share_nonce)
   );
endmodule

// File: tb/tb_share_queue.sv
// Directed + scoreboard bench for share_queue (DEPTH=8); hash_count is checked
// when SHARE_QUEUE_STATS_EN is defined.
module tb_share_queue;
   localparam int DEPTH = 8;
   localparam int NW    = 32;

   logic          clk = 1'b0, rst = 1'b1;
   logic          res_valid = 1'b0, res_hit = 1'b0, flush = 1'b0, share_ready = 1'b0;
   logic [NW-1:0] res_nonce = '0;
   logic          share_valid, overflow;
   logic [NW-1:0] share_nonce;
   logic [3:0]    level;
   logic [15:0]   dropped;
`ifdef SHARE_QUEUE_STATS_EN
   logic [47:0]   hash_count;
`endif

   int            n_vec = 0, n_err = 0;
   logic [NW-1:0] exp_q[$];
   logic [15:0]   m_drop = '0;
   logic          m_ovf = 1'b0;
   logic [47:0]   m_hash = '0;

   share_queue #(.DEPTH(DEPTH), .NONCE_W(NW)) dut (
      .clk(clk), .rst(rst), .res_valid(res_valid), .res_hit(res_hit),
      .res_nonce(res_nonce), .flush(flush), .share_valid(share_valid),
      .share_ready(share_ready), .share_nonce(share_nonce), .level(level),
      .dropped(dropped), .overflow(overflow)
`ifdef SHARE_QUEUE_STATS_EN
      , .hash_count(hash_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic h, input logic [NW-1:0] n,
                        input logic rdy, input logic fl);
      res_valid = v; res_hit = h; res_nonce = n; share_ready = rdy; flush = fl;
   endtask

   // One clock: score the head if it leaves, update the model, check state after the edge.
   task automatic cycle();
      logic pop;
      pop = !rst && exp_q.size() != 0 && share_ready;
      if (pop) chk("head_nonce", {32'h0, share_nonce}, {32'h0, exp_q[0]});
      @(posedge clk);
      if (rst) begin
         exp_q.delete(); m_drop = '0; m_ovf = 1'b0; m_hash = '0;
      end else begin
         if (res_valid) m_hash = m_hash + 1'b1;
         if (flush) exp_q.delete();
         else begin
            if (pop) void'(exp_q.pop_front());
            if (res_valid && res_hit) begin
               if (exp_q.size() < DEPTH) exp_q.push_back(res_nonce);
               else begin
                  m_ovf = 1'b1;
                  if (m_drop != 16'hFFFF) m_drop = m_drop + 1'b1;
               end
            end
         end
      end
      #1;
      chk("level", 64'(level), 64'(exp_q.size()));
      chk("share_valid", 64'(share_valid), 64'(exp_q.size() != 0));
      chk("dropped", 64'(dropped), 64'(m_drop));
      chk("overflow", 64'(overflow), 64'(m_ovf));
`ifdef SHARE_QUEUE_STATS_EN
      chk("hash_count", 64'(hash_count), 64'(m_hash));
`endif
   endtask

   initial begin
      // reset, with a hit presented that must be discarded
      drive(1, 1, 32'hDEAD, 1, 0);
      cycle(); cycle();
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_valid", 64'(share_valid), 64'd0);

      // hit on the first edge after reset release, popped one cycle later
      rst = 1'b0;
      drive(1, 1, 32'h5, 1, 0);
      cycle();
      chk("t1_valid", 64'(share_valid), 64'd1);
      chk("t1_nonce", 64'(share_nonce), 64'd5);
      drive(0, 0, 0, 1, 0);
      cycle();
      chk("t1_level0", 64'(level), 64'd0);

      // 10 hits into a blocked queue
      for (int i = 1; i <= 10; i++) begin
         drive(1, 1, NW'(i), 0, 0);
         cycle();
      end
      chk("t2_level", 64'(level), 64'd8);
      chk("t2_dropped", 64'(dropped), 64'd2);
      chk("t2_overflow", 64'(overflow), 64'd1);
      chk("t2_hold", 64'(share_nonce), 64'd1);

      // full queue: hit together with a pop
      drive(1, 1, 32'd11, 1, 0);
      cycle();
      chk("t3_level", 64'(level), 64'd8);
      chk("t3_dropped", 64'(dropped), 64'd2);
      drive(0, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) cycle();
      chk("t3_drained", 64'(level), 64'd0);

      // flush with a simultaneous hit and pop
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, NW'(20 + i), 0, 0);
         cycle();
      end
      drive(1, 1, 32'd23, 1, 1);
      cycle();
      chk("t4_level", 64'(level), 64'd0);
      chk("t4_valid", 64'(share_valid), 64'd0);
      chk("t4_dropped", 64'(dropped), 64'd2);

      // misses only
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, NW'($urandom), 1'($urandom_range(0, 1)), 0);
         cycle();
      end
      chk("t5_level", 64'(level), 64'd0);
`ifdef SHARE_QUEUE_STATS_EN
      chk("t5_hash", 64'(hash_count), 64'd36);
`endif

      // random mix
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), NW'($urandom),
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 24) == 0));
         cycle();
      end

      // drop counter saturation
      drive(1, 1, 32'hABCD, 0, 0);
      for (int i = 0; i < 70000 && m_drop != 16'hFFFF; i++) cycle();
      cycle(); cycle();
      chk("sat_dropped", 64'(dropped), 64'hFFFF);
      chk("sat_level", 64'(level), 64'd8);

      // leave 4 entries, then assert reset between edges
      drive(0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) cycle();
      chk("pre_rst_level", 64'(level), 64'd4);
      share_ready = 1'b0;
      #3 rst = 1'b1;
      #1;
      chk("async_valid", 64'(share_valid), 64'd0);
      chk("async_level", 64'(level), 64'd0);
      chk("async_dropped", 64'(dropped), 64'd0);
      chk("async_overflow", 64'(overflow), 64'd0);
      cycle();
      rst = 1'b0;
      drive(1, 1, 32'h77, 0, 0);
      cycle();
      chk("post_rst_nonce", 64'(share_nonce), 64'h77);
      drive(0, 0, 0, 1, 0);
      cycle(); cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/share_queue.md
SHARE_QUEUE -- requirements
Module: share_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning queue entries; power of two, 2..64.
REQ-002 SHALL have parameter NONCE_W, default 32, meaning width of nonce and output data.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port res_valid  input  1  one hash result presented this cycle (comparator write strobe).
REQ-006 SHALL have port res_hit  input  1  result met target (comparator out); sampled only when res_valid=1.
REQ-007 SHALL have port res_nonce  input  NONCE_W  nonce belonging to the presented result.
REQ-008 SHALL have port flush  input  1  discard all queued shares (new work loaded).
REQ-009 SHALL have port share_valid  output  1  head entry available.
REQ-010 SHALL have port share_ready  input  1  consumer accepts head entry.
REQ-011 SHALL have port share_nonce  output  NONCE_W  head entry nonce.
REQ-012 SHALL have port level  output  clog2(DEPTH+1)  current entry count.
REQ-013 SHALL have port dropped  output  16  count of hits lost to a full queue.
REQ-014 SHALL have port overflow  output  1  sticky flag, set on first drop.

Function
REQ-015 SHALL push res_nonce when res_valid=1 and res_hit=1; res_valid=1 with res_hit=0 does not push.
REQ-016 SHALL pop the head entry on a cycle where share_valid=1 and share_ready=1.
REQ-017 SHALL give a 1-cycle latency from push to share_valid, with no same-cycle bypass; a push into an empty queue with share_ready=1 pops on the next cycle.
REQ-018 SHALL keep share_nonce stable while share_valid=1 and share_ready=0.
REQ-019 SHALL keep share_valid deasserted while the queue is empty; share_nonce is then don't-care.
REQ-020 SHALL accept a push when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
REQ-021 SHALL drop a push when the queue is full with no pop: queue unchanged, dropped incremented, overflow set.
REQ-022 SHALL saturate dropped at 16'hFFFF.
REQ-023 SHALL preserve order: entries leave in arrival order.
REQ-024 SHALL, on flush=1, empty the queue on the next edge; flush takes priority over a same-cycle push and pop, and a push discarded by flush is not counted as a drop.
REQ-025 SHALL leave dropped and overflow unchanged on flush.
REQ-026 SHALL implement level as a registered count equal to pushes minus pops; read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.

Reset
REQ-027 SHALL, while rst=1, hold share_valid=0, level=0, dropped=0, overflow=0 and both pointers at 0; share_nonce is don't-care.
REQ-028 SHALL discard any push or pop presented while rst=1.
REQ-029 SHALL accept a push on the first rising edge after rst deasserts.
REQ-030 SHALL not reset the storage array.

Configuration
REQ-031 SHALL, when macro SHARE_QUEUE_STATS_EN is defined, add output hash_count (48 bits), incremented on every res_valid=1 (hit or not), wrapping at 2^48, cleared only by rst and not by flush.
REQ-032 SHALL, when SHARE_QUEUE_STATS_EN is undefined, omit the hash_count port and its counter; all other behaviour is identical.

Structure
REQ-033 SHALL place the default NONCE_W (32), the dropped width (16) and the hash_count width (48) as constants in shared package miner_pkg.
REQ-034 SHALL hold the storage in one sub-module, share_ring, providing DEPTH x NONCE_W registers with one write port and one registered read port; pointers, count and flags stay in share_queue.

Verification
REQ-035 SHALL cover: reset, then hit with nonce 32'h0000_0005 and share_ready=1 -> share_valid rises 1 cycle later with share_nonce=5; level returns to 0 after the pop.
REQ-036 SHALL cover: 10 hits (nonces 1..10) with share_ready=0 and DEPTH=8 -> level=8, dropped=2, overflow=1; draining yields 1..8 in order.
REQ-037 SHALL cover: queue full and a hit arrives together with a pop -> level stays 8, dropped unchanged, new nonce appears last.
REQ-038 SHALL cover: 3 entries queued, then flush with a simultaneous hit -> level=0 and share_valid=0 next cycle, dropped unchanged.
REQ-039 SHALL cover: 20 res_valid pulses with res_hit=0 -> level=0 and, with SHARE_QUEUE_STATS_EN, hash_count=20.
REQ-040 SHALL cover: rst asserted mid-stream with 4 entries queued -> share_valid, level, dropped and overflow clear immediately without waiting for a clock edge.
